// File: rtl/reorder_out_buffer_pkg.sv
// reorder_out_buffer_pkg: shared sample, bank-state and per-frame config types
package reorder_out_buffer_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int REV_W = 16;
  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] im;
    logic signed [DEF_DATA_W-1:0] re;
  } sample_t;
  typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_st_t;
  typedef struct packed {
    logic [3:0] log2n;
    logic       ifft;
    logic       bitrev;
    logic [3:0] shift;
  } cfg_t;
  function automatic logic [REV_W-1:0] bit_reverse(input logic [REV_W-1:0] v, input logic [3:0] l);
    logic [REV_W-1:0] r;
    r = '0;
    for (int i = 0; i < REV_W; i++)
      if (i < int'(l)) r[4'(i)] = v[4'(int'(l) - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/reorder_out_buffer_ram.sv
// reorder_out_buffer_ram: single-port synchronous RAM with registered read data
module reorder_out_buffer_ram #(
  parameter int W = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/reorder_out_buffer.sv
// reorder_out_buffer: multi-bank frame buffer that reorders (bit-reversed or natural)
// and scales FFT samples, draining frames in fill order through a 2-entry skid buffer.
module reorder_out_buffer
  import reorder_out_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_LOG2N = 9,
  parameter int NBANK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2*DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [3:0]        cfg_log2n,
  input  logic              cfg_ifft,
  input  logic              cfg_bitrev,
  input  logic [3:0]        cfg_final_shift,
  output logic              out_valid,
  output logic [2*DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              pop,
  output logic              overflow
);
  localparam int AW = MAX_LOG2N;
  localparam int BW = (NBANK > 2) ? 2 : 1;
  localparam int SW = 2*DATA_W;
  typedef struct packed {
    logic signed [DATA_W-1:0] im;
    logic signed [DATA_W-1:0] re;
  } smp_t;
  bank_st_t      st [NBANK];
  cfg_t          bcfg [NBANK];
  logic [SW-1:0] rdata [NBANK];
  logic [BW-1:0] wr_bank, rd_bank, p1_bank;
  logic [AW-1:0] wr_cnt, rd_cnt;
  logic          p1_valid, p1_last;
  smp_t          f_data [2];
  logic          f_last [2];
  logic [BW-1:0] f_bank [2];
  logic          f_wp, f_rp;
  logic [1:0]    f_cnt;
  cfg_t          wcfg;
  logic          wr_en, rd_en, accept, wr_last, rd_last;
  logic [AW-1:0] waddr;
  smp_t          win, wdat, p1_raw, p1_out;
  function automatic logic [AW-1:0] frame_mask(input logic [3:0] l);
    return AW'((32'd1 << l) - 32'd1);
  endfunction
  function automatic logic [BW-1:0] nxt(input logic [BW-1:0] b);
    return (b == BW'(NBANK-1)) ? '0 : b + 1'b1;
  endfunction
  function automatic logic [DATA_W-1:0] sat_shl(input logic [DATA_W-1:0] x, input logic [3:0] sh);
    logic [DATA_W+15:0] w;
    logic ovf;
    w = {{16{x[DATA_W-1]}}, x} << sh;
    ovf = (w[DATA_W+15:DATA_W-1] != '0) && (w[DATA_W+15:DATA_W-1] != '1);
    return ovf ? {w[DATA_W+15], {(DATA_W-1){~w[DATA_W+15]}}} : w[DATA_W-1:0];
  endfunction
  always_comb begin
    wcfg = (st[wr_bank] == BANK_FREE) ? cfg_t'({cfg_log2n, cfg_ifft, cfg_bitrev, cfg_final_shift}) : bcfg[wr_bank];
    in_ready = (st[wr_bank] == BANK_FREE) || (st[wr_bank] == BANK_FILLING);
    wr_en = in_valid && in_ready;
    wr_last = wr_cnt == frame_mask(wcfg.log2n);
    waddr = wcfg.bitrev ? AW'(bit_reverse(REV_W'(wr_cnt), wcfg.log2n)) : wr_cnt;
    win = smp_t'(in_data);
    wdat = win;
    wdat.re = wcfg.ifft ? ($signed(win.re) >>> wcfg.log2n) : win.re;
    wdat.im = wcfg.ifft ? ($signed(win.im) >>> wcfg.log2n) : win.im;
    rd_last = rd_cnt == frame_mask(bcfg[rd_bank].log2n);
    accept = (f_cnt != 2'd0) && out_ready;
    // Issue a read only if the skid buffer can still absorb it once it lands.
    rd_en = ((st[rd_bank] == BANK_FULL) || (st[rd_bank] == BANK_DRAINING && rd_cnt != '0))
            && (({1'b0, f_cnt} + {2'b0, p1_valid}) <= (3'd1 + {2'b0, accept}));
    p1_raw = smp_t'(rdata[p1_bank]);
    p1_out.re = sat_shl(p1_raw.re, bcfg[p1_bank].shift);
    p1_out.im = sat_shl(p1_raw.im, bcfg[p1_bank].shift);
  end
  assign out_valid = f_cnt != 2'd0;
  assign out_data = f_data[f_rp];
  assign out_last = f_last[f_rp];
  assign pop = accept;
  // A bank is written only while FREE/FILLING and read only while FULL/DRAINING.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic wsel, rsel;
    assign wsel = wr_en && (wr_bank == BW'(b));
    assign rsel = rd_en && (rd_bank == BW'(b));
    reorder_out_buffer_ram #(.W(SW), .AW(AW)) u_ram (
      .clk(clk),
      .en(wsel || rsel),
      .we(wsel),
      .addr(wsel ? waddr : rd_cnt),
      .wdata(wdat),
      .rdata(rdata[b])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBANK; i++) begin
        st[i] <= BANK_FREE;
        bcfg[i] <= '0;
      end
      wr_bank <= '0;
      rd_bank <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      p1_valid <= 1'b0;
      p1_last <= 1'b0;
      p1_bank <= '0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_last[i] <= 1'b0;
        f_bank[i] <= '0;
      end
      f_wp <= 1'b0;
      f_rp <= 1'b0;
      f_cnt <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (wr_en) begin
        bcfg[wr_bank] <= wcfg;
        st[wr_bank] <= wr_last ? BANK_FULL : BANK_FILLING;
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        if (wr_last) wr_bank <= nxt(wr_bank);
      end
      if (rd_en) begin
        st[rd_bank] <= BANK_DRAINING;
        rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
        if (rd_last) rd_bank <= nxt(rd_bank);
      end
      p1_valid <= rd_en;
      p1_last <= rd_en && rd_last;
      p1_bank <= rd_bank;
      if (p1_valid) begin
        f_data[f_wp] <= p1_out;
        f_last[f_wp] <= p1_last;
        f_bank[f_wp] <= p1_bank;
        f_wp <= ~f_wp;
      end
      if (accept) begin
        f_rp <= ~f_rp;
        if (f_last[f_rp]) st[f_bank[f_rp]] <= BANK_FREE;
      end
      f_cnt <= f_cnt + {1'b0, p1_valid} - {1'b0, accept};
    end
  end
endmodule

// File: tb/tb_reorder_out_buffer.sv
// tb_reorder_out_buffer: directed and randomized scoreboard bench for reorder_out_buffer
module tb_reorder_out_buffer;
  import reorder_out_buffer_pkg::*;
  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cfg_ifft = 1'b0, cfg_bitrev = 1'b0;
  logic        in_ready, out_valid, out_last, out_ready, pop, overflow;
  logic [31:0] in_data = '0;
  logic [31:0] out_data;
  logic [3:0]  cfg_log2n = 4'd3, cfg_final_shift = 4'd0;
  logic        rnd_ready = 1'b0, fix_ready = 1'b1, rnd_bit = 1'b1;
  exp_t        exp_q[$];
  logic [31:0] fr [16];
  int          ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int          vectors = 0, miscompares = 0, pops = 0;

  reorder_out_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_log2n(cfg_log2n), .cfg_ifft(cfg_ifft), .cfg_bitrev(cfg_bitrev),
    .cfg_final_shift(cfg_final_shift), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .pop(pop), .overflow(overflow)
  );

  always #5 clk = ~clk;
  assign out_ready = rnd_ready ? rnd_bit : fix_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int rev(input int j, input int l);
    int r;
    r = 0;
    for (int i = 0; i < l; i++) if (j[i]) r |= 1 << (l - 1 - i);
    return r;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d, input int l, input bit ifft, input int sh);
    sample_t s;
    int c [2];
    s = sample_t'(d);
    c[0] = $signed(s.re);
    c[1] = $signed(s.im);
    for (int i = 0; i < 2; i++) begin
      if (ifft) c[i] = c[i] >>> l;
      c[i] = c[i] * (1 << sh);
      if (c[i] > 32767) c[i] = 32767;
      if (c[i] < -32768) c[i] = -32768;
    end
    return {16'(c[1]), 16'(c[0])};
  endfunction

  task automatic put(input logic [31:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (n == 2000) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int l, input bit ifft, input bit br, input int sh, input bit push);
    int n;
    exp_t e;
    n = 1 << l;
    if (push)
      for (int j = 0; j < n; j++) begin
        e.d = model(fr[br ? rev(j, l) : j], l, ifft, sh);
        e.l = (j == n - 1);
        exp_q.push_back(e);
      end
    cfg_log2n = 4'(l);
    cfg_ifft = ifft;
    cfg_bitrev = br;
    cfg_final_shift = 4'(sh);
    for (int k = 0; k < n; k++) begin
      put(fr[k]);
      cfg_log2n = 4'($urandom_range(1, 9));
      cfg_ifft = 1'($urandom_range(0, 1));
      cfg_bitrev = 1'($urandom_range(0, 1));
      cfg_final_shift = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 4000) begin @(posedge clk); n++; end
    #1;
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (pop) pops++;
    if (out_valid && out_ready) begin
      chk("pop_on_accept", 64'(pop), 64'd1);
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL spurious_output observed=%0h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_last", 64'(out_last), 64'(e.l));
      end
    end else if (out_valid) chk("pop_while_stalled", 64'(pop), 64'd0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int l;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) fr[k] = {16'(32 + k), 16'(k)};
    for (int j = 0; j < 8; j++) begin
      exp_t e;
      e.d = {16'(32 + ord[j]), 16'(ord[j])};
      e.l = (j == 7);
      exp_q.push_back(e);
    end
    pops = 0;
    send_frame(3, 1'b0, 1'b1, 0, 1'b0);
    wait_drain("bitrev");
    chk("bitrev_pops", 64'(pops), 64'd8);

    fr[0] = {16'(8), 16'(16)};
    fr[1] = {16'(3), 16'(-16)};
    fr[2] = {16'(-9), 16'(40)};
    fr[3] = {16'(100), 16'(7)};
    send_frame(2, 1'b1, 1'b0, 0, 1'b1);
    wait_drain("ifft");

    fr[0] = {16'h0123, 16'h1000};
    fr[1] = {16'hFFFF, 16'hF000};
    send_frame(1, 1'b0, 1'b0, 4, 1'b1);
    wait_drain("saturate");

    fix_ready = 1'b0;
    for (int k = 0; k < 8; k++) fr[k] = {16'(k), 16'(256 + k)};
    send_frame(3, 1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 8; k++) fr[k] = {16'(k), 16'(512 + k)};
    send_frame(3, 1'b0, 1'b0, 0, 1'b1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("no_overflow_yet", 64'(overflow), 64'd0);
    chk("held_data_a", 64'(out_data), 64'h100);
    in_valid = 1'b1;
    in_data = 32'hDEAD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overflow_set", 64'(overflow), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("held_data_b", 64'(out_data), 64'h100);
    chk("held_valid", 64'(out_valid), 64'd1);
    fix_ready = 1'b1;
    wait_drain("backpressure");

    rnd_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      l = $urandom_range(1, 4);
      for (int k = 0; k < 16; k++) fr[k] = $urandom;
      send_frame(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
    end
    wait_drain("random");
    rnd_ready = 1'b0;

    for (int k = 0; k < 8; k++) fr[k] = {16'(64 + k), 16'(k + 1)};
    send_frame(3, 1'b0, 1'b1, 2, 1'b1);
    n = 0;
    while (exp_q.size() > 4 && n < 200) begin @(posedge clk); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_pop", 64'(pop), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) fr[k] = {16'(-k), 16'(1000 + k)};
    send_frame(2, 1'b0, 1'b1, 1, 1'b1);
    wait_drain("post_reset");
    chk("final_idle", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reorder_out_buffer.md
REORDER_OUT_BUFFER -- requirements
Module: reorder_out_buffer

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, width of each real/imag component.
REQ-002 SHALL have parameters: MAX_LOG2N, default 9, largest frame = 2^MAX_LOG2N points.
REQ-003 SHALL have parameters: NBANK, default 2, range 2..4, number of frame banks.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: in_valid  in  1  input sample strobe.
REQ-007 SHALL have ports: in_data  in  2*DATA_W  {imag, real}, signed.
REQ-008 SHALL have ports: in_ready  out  1  high when a bank can accept a sample.
REQ-009 SHALL have ports: cfg_log2n  in  4  frame size code, 1..MAX_LOG2N.
REQ-010 SHALL have ports: cfg_ifft  in  1  enable IFFT input scaling.
REQ-011 SHALL have ports: cfg_bitrev  in  1  1 = bit-reverse reorder, 0 = natural order.
REQ-012 SHALL have ports: cfg_final_shift  in  4  output left shift.
REQ-013 SHALL have ports: out_valid  out  1  output sample valid.
REQ-014 SHALL have ports: out_data  out  2*DATA_W  {imag, real}.
REQ-015 SHALL have ports: out_last  out  1  high with the final sample of a frame.
REQ-016 SHALL have ports: out_ready  in  1  downstream accept.
REQ-017 SHALL have ports: pop  out  1  one-cycle pulse per accepted output sample, to controller.
REQ-018 SHALL have ports: overflow  out  1  sticky; in_valid seen while in_ready low.

Function
REQ-019 A write SHALL occur when in_valid and in_ready are both high.
REQ-020 Writes SHALL fill banks round-robin: 0, 1, ..., NBANK-1, 0.
REQ-021 Each bank SHALL cycle FREE -> FILLING -> FULL -> DRAINING -> FREE.
REQ-022 cfg_log2n, cfg_ifft, cfg_bitrev and cfg_final_shift SHALL be latched per bank on the first write of a frame; mid-frame cfg changes SHALL be ignored.
REQ-023 Write address SHALL be the write counter bit-reversed over the low L = latched log2n bits when bitrev = 1, else the counter unchanged.
REQ-024 When ifft = 1, each component SHALL be arithmetic-right-shifted by L before storage.
REQ-025 A bank SHALL go FILLING -> FULL on write 2^L - 1; the write counter SHALL wrap to 0.
REQ-026 in_ready SHALL be low only when the next bank in order is not FREE.
REQ-027 Reads SHALL drain FULL banks in fill order at sequential addresses 0 .. 2^L - 1.
REQ-028 Read data SHALL be each component left-shifted by the bank's final_shift, saturated to signed DATA_W.
REQ-029 Latency from the sample's read address to out_valid SHALL be 2 cycles: RAM read, then output register.
REQ-030 A 2-entry skid buffer SHALL hold out_valid/out_data stable while out_ready is low; no sample SHALL be dropped or duplicated.
REQ-031 pop SHALL pulse in the cycle an output is accepted (out_valid and out_ready both high).
REQ-032 A bank SHALL return to FREE in the cycle its last sample is accepted; it may be refilled the following cycle.
REQ-033 A write and a read in the same cycle to different banks SHALL both proceed.

Reset
REQ-034 On rst_n low, asynchronously: all banks FREE, counters 0, skid buffer empty.
REQ-035 On rst_n low, asynchronously: out_valid, out_last, pop and overflow = 0, out_data = 0, in_ready = 1.
REQ-036 A reset asserted mid-frame SHALL discard all buffered data; RAM contents need not be cleared.

Structure
REQ-037 A shared package SHALL define SAMPLE_T (2*DATA_W struct {imag, real}), the bank-state enum and the cfg struct.
REQ-038 The block SHALL instantiate NBANK copies of the existing single-port ram sub-module (width 2*DATA_W, depth 2^MAX_LOG2N).
REQ-039 Per-bank port arbitration SHALL be unambiguous because a bank is never FILLING and DRAINING at the same time.

Verification
REQ-040 Bench SHALL cover: log2n=3, bitrev=1, inputs 0..7, out_ready=1 -> outputs 0,4,2,6,1,5,3,7; out_last on the 8th; 8 pop pulses.
REQ-041 Bench SHALL cover: log2n=2, bitrev=0, ifft=1, real input 16 -> stored and output 4 (16>>>2).
REQ-042 Bench SHALL cover: final_shift=4, DATA_W=16, real 0x1000 -> 0x7FFF saturated; real -0x1000 -> -0x8000.
REQ-043 Bench SHALL cover: NBANK=2, log2n=3, out_ready=0, 16 inputs then a 17th -> in_ready low after the 16th; 17th sets overflow; out_data held constant.
REQ-044 Bench SHALL cover: random out_ready toggling over 10 frames -> output sequence matches reference model exactly; no loss or duplication.
REQ-045 Bench SHALL cover: rst_n pulse mid-drain -> outputs 0 asynchronously; the next frame after reset is output correctly from bank 0.
